// File: rtl/oric_tape_modulator.sv
// rtl/oric_tape_modulator.sv - Oric cassette byte/gap serialiser: one frame or gap per accepted start

module oric_tape_modulator #(
    parameter int T_SHORT    = 2496,
    parameter int T_LONG     = 4992,
    parameter int STOP_BITS  = 4,
    parameter int GAP_CYCLES = 2400000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       gap,
    input  logic [7:0] din,
    output logic       done,
    output logic       busy,
    output logic       dout
);

    localparam int FW = 10 + STOP_BITS;
    localparam logic [23:0] SHORT_M1 = 24'(T_SHORT - 1);
    localparam logic [23:0] LONG_M1  = 24'(T_LONG - 1);
    localparam logic [23:0] GAP_M1   = 24'(GAP_CYCLES - 1);
    localparam logic [3:0]  FW_BITS  = 4'(FW);

    typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} state_t;

    state_t          state_q, state_d;
    logic [23:0]     cnt_q, cnt_d;
    logic [FW-1:0]   sh_q, sh_d;
    logic [3:0]      bits_q, bits_d;
    logic            done_q, done_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            bits_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            bits_q  <= bits_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        bits_d  = bits_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (gap) begin
                        state_d = GAP;
                        cnt_d   = GAP_M1;
                    end else begin
                        // Frame goes out LSB first: start 0, data, odd parity, stop ones
                        sh_d    = {{STOP_BITS{1'b1}}, ~^din, din, 1'b0};
                        bits_d  = FW_BITS;
                        cnt_d   = SHORT_M1;
                        state_d = BIT_HI;
                    end
                end
            end
            BIT_HI: begin
                if (cnt_q == 24'd0) begin
                    state_d = BIT_LO;
                    cnt_d   = sh_q[0] ? SHORT_M1 : LONG_M1;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            BIT_LO: begin
                if (cnt_q == 24'd0) begin
                    sh_d   = sh_q >> 1;
                    bits_d = bits_q - 4'd1;
                    if (bits_q == 4'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = BIT_HI;
                        cnt_d   = SHORT_M1;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            GAP: begin
                if (cnt_q == 24'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout = (state_q == BIT_HI);
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_oric_tape_modulator.sv
// tb/tb_oric_tape_modulator.sv - self-checking bench for oric_tape_modulator

module tb_oric_tape_modulator;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       gap;
    logic [7:0] din;
    logic       done;
    logic       busy;
    logic       dout;

    oric_tape_modulator #(
        .T_SHORT(2),
        .T_LONG(4),
        .STOP_BITS(4),
        .GAP_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .gap(gap),
        .din(din),
        .done(done),
        .busy(busy),
        .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       g;
        logic [7:0] d;
        int         len;
    } vec_t;

    vec_t       vecs[6];
    logic [2:0] exp_q[$];
    int         checks;
    int         errors;
    int         cyc;
    int         done_cnt;
    logic       seen_done;

    // Per-cycle expectation {dout, busy, done}; an empty queue means idle
    task automatic tick();
        logic [2:0] e;
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
        checks++;
        if ({dout, busy, done} !== e) begin
            errors++;
            $display("FAIL wave cyc=%0d got dout/busy/done=%b required=%b", cyc, {dout, busy, done}, e);
        end
        seen_done = done;
        if (done) done_cnt++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic g, input logic [7:0] d);
        logic [13:0] b;
        if (g) begin
            repeat (10) exp_q.push_back(3'b010);
        end else begin
            b = {4'hF, ~^d, d, 1'b0};
            for (int i = 0; i < 14; i++) begin
                repeat (2) exp_q.push_back(3'b110);
                repeat (b[i] ? 2 : 4) exp_q.push_back(3'b010);
            end
        end
        exp_q.push_back(3'b001);
    endtask

    task automatic send(input logic g, input logic [7:0] d);
        start = 1'b1;
        gap   = g;
        din   = d;
        tick();
        start = 1'b0;
        push_frame(g, d);
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        int k;
        k = 0;
        seen_done = 1'b0;
        while (!seen_done && k < 300) begin
            tick();
            k++;
        end
        checks++;
        if (!seen_done || k != exp_lat) begin
            errors++;
            $display("FAIL latency %s got=%0d seen=%0d required=%0d", name, k, seen_done, exp_lat);
        end
    endtask

    initial begin
        logic [2:0] keep;
        int         d0;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        done_cnt  = 0;
        seen_done = 1'b0;

        vecs[0] = '{1'b0, 8'h00, 74};
        vecs[1] = '{1'b0, 8'h16, 70};
        vecs[2] = '{1'b0, 8'hFF, 58};
        vecs[3] = '{1'b1, 8'h3C, 10};
        vecs[4] = '{1'b0, 8'hA5, 66};
        vecs[5] = '{1'b0, 8'h80, 74};

        // Reset held with start asserted: outputs stay idle
        reset_n = 1'b0;
        start   = 1'b1;
        gap     = 1'b0;
        din     = 8'h55;
        @(posedge clk);
        #1;
        repeat (4) tick();
        start   = 1'b0;
        reset_n = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].g, vecs[i].d);
            wait_done(vecs[i].len + 1, $sformatf("vec%0d", i));
            repeat (2) tick();
        end

        // Back-to-back: second start lands on the done cycle of the first
        send(1'b0, 8'h16);
        repeat (70) tick();
        send(1'b0, 8'h24);
        wait_done(71, "b2b");
        repeat (2) tick();

        // Start while busy in a gap is ignored
        d0 = done_cnt;
        send(1'b1, 8'h00);
        repeat (2) tick();
        start = 1'b1;
        gap   = 1'b0;
        din   = 8'hFF;
        tick();
        start = 1'b0;
        wait_done(8, "gap_ign");
        repeat (6) tick();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL gap_done_count got=%0d required=1", done_cnt - d0);
        end

        // Reset mid-frame aborts with no done
        d0 = done_cnt;
        send(1'b0, 8'h16);
        repeat (19) tick();
        reset_n = 1'b0;
        keep = exp_q[0];
        exp_q.delete();
        exp_q.push_back(keep);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL abort_done got=%0d required=0", done_cnt - d0);
        end
        send(1'b0, 8'h16);
        wait_done(71, "after_abort");
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
